// File: rtl/write_rr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// write_rr_arbiter_pkg
//   Shared definitions for the round-robin write arbiter:
//   - the FSM state encoding
//   - the port id width
//   - the default parameter values
//   - a helper that advances a port index with wrap-around
//   No ports; imported by the interface, the priority picker and the top.
// ---------------------------------------------------------------------------
package write_rr_arbiter_pkg;

  localparam int PORT_ID_W             = 4;
  localparam int DEFAULT_NUM_OF_PORTS  = 16;
  localparam int DEFAULT_MAX_BURST_LEN = 64;
  localparam int DEFAULT_CNT_WIDTH     = 6;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  typedef logic [PORT_ID_W-1:0] port_id_t;

  // Index of the port after idx, wrapping back to 0 past the last port.
  // The extra sum bit keeps idx = 15 from silently wrapping before the
  // compare against n.
  function automatic port_id_t next_port(input port_id_t idx, input int n);
    logic [PORT_ID_W:0] sum;
    sum = {1'b0, idx} + 1'b1;
    if (int'(sum) >= n) begin
      return '0;
    end
    return sum[PORT_ID_W-1:0];
  endfunction

endpackage

// File: rtl/write_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// write_rr_arbiter_if
//   Bundles the request side and the channel-selector side of the write
//   arbiter.
//   Signals:
//     wr_req    : per-port request
//     wr_last   : per-port last-beat flag
//     enable    : beat valid to the channel selector
//     select    : granted port index
//     grant     : one-hot acknowledge to the granted port
//     pkt_done  : one-cycle pulse on normal release
//     pkt_abort : one-cycle pulse on abort
//   Modports:
//     master : the requesters (drive wr_req/wr_last, observe the rest)
//     slave  : the arbiter
// ---------------------------------------------------------------------------
interface write_rr_arbiter_if
  import write_rr_arbiter_pkg::*;
#(
  parameter int num_of_ports = DEFAULT_NUM_OF_PORTS
);

  logic [num_of_ports-1:0] wr_req;
  logic [num_of_ports-1:0] wr_last;
  logic                    enable;
  port_id_t                select;
  logic [num_of_ports-1:0] grant;
  logic                    pkt_done;
  logic                    pkt_abort;

  modport master (
    output wr_req, wr_last,
    input  enable, select, grant, pkt_done, pkt_abort
  );

  modport slave (
    input  wr_req, wr_last,
    output enable, select, grant, pkt_done, pkt_abort
  );

endinterface

// File: rtl/write_rr_arbiter_rr_priority_pick.sv
// ---------------------------------------------------------------------------
// rr_priority_pick
//   Combinational rotating-priority search. Scans req starting at ptr and
//   moving upward, wrapping modulo num_of_ports. Reports whether any bit is
//   set and, if so, the index of the first set bit found.
//   Ports:
//     req   (in)  : request vector
//     ptr   (in)  : index with the highest priority this cycle
//     any   (out) : at least one request is present
//     index (out) : winning index (0 when no request is present)
// ---------------------------------------------------------------------------
module rr_priority_pick
  import write_rr_arbiter_pkg::*;
#(
  parameter int num_of_ports = DEFAULT_NUM_OF_PORTS
) (
  input  logic [num_of_ports-1:0] req,
  input  port_id_t                ptr,
  output logic                    any,
  output port_id_t                index
);

  // The first hit wins; once any is set, later candidates are ignored.
  always_comb begin
    int cand;
    any   = 1'b0;
    index = '0;
    cand  = 0;
    for (int i = 0; i < num_of_ports; i++) begin
      cand = int'(ptr) + i;
      if (cand >= num_of_ports) begin
        cand = cand - num_of_ports;
      end
      if (!any && req[cand[PORT_ID_W-1:0]]) begin
        any   = 1'b1;
        index = cand[PORT_ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/write_rr_arbiter.sv
// ---------------------------------------------------------------------------
// write_rr_arbiter
//   Round-robin write arbiter. Grants one requesting port at a time for a
//   whole packet and drives enable/select to the downstream channel selector.
//   A grant ends in one of three ways:
//     - the port drops its request (abort)
//     - the port signals its last beat (done)
//     - the beat limit is reached (done)
//   On every release the priority pointer moves just past the released port.
//   Ports:
//     clk : rising-edge clock
//     rst : asynchronous, active-low reset
//     bus : write_rr_arbiter_if.slave
//           (inputs  : wr_req, wr_last;
//            outputs : enable, select, grant, pkt_done, pkt_abort)
// ---------------------------------------------------------------------------
module write_rr_arbiter
  import write_rr_arbiter_pkg::*;
#(
  parameter int num_of_ports  = DEFAULT_NUM_OF_PORTS,
  parameter int max_burst_len = DEFAULT_MAX_BURST_LEN,
  parameter int cnt_width     = DEFAULT_CNT_WIDTH
) (
  input  logic clk,
  input  logic rst,
  write_rr_arbiter_if.slave bus
);

  localparam logic [cnt_width-1:0]    LAST_BEAT = cnt_width'(max_burst_len - 1);
  localparam logic [num_of_ports-1:0] ONE_HOT0  = {{(num_of_ports-1){1'b0}}, 1'b1};

  arb_state_e              state;
  port_id_t                ptr;
  logic [cnt_width-1:0]    beat_cnt;
  logic                    enable_q;
  port_id_t                select_q;
  logic [num_of_ports-1:0] grant_q;
  logic                    done_q;
  logic                    abort_q;

  logic                    pick_any;
  port_id_t                pick_idx;

  rr_priority_pick #(
    .num_of_ports(num_of_ports)
  ) u_pick (
    .req   (bus.wr_req),
    .ptr   (ptr),
    .any   (pick_any),
    .index (pick_idx)
  );

  // FSM, beat counter and all outputs are registered together.
  // While in GRANT only the selected port's request and last bits are
  // looked at; the checks are ordered abort, then last beat, then beat
  // limit. Every release drops enable/grant on the next cycle, which
  // guarantees an IDLE cycle before the next winner is picked. select is
  // deliberately left unchanged on release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ptr      <= '0;
      beat_cnt <= '0;
      enable_q <= 1'b0;
      select_q <= '0;
      grant_q  <= '0;
      done_q   <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            state    <= GRANT;
            select_q <= pick_idx;
            grant_q  <= ONE_HOT0 << pick_idx;
            enable_q <= 1'b1;
            beat_cnt <= '0;
          end else begin
            enable_q <= 1'b0;
            grant_q  <= '0;
          end
        end
        GRANT: begin
          if (!bus.wr_req[select_q] || bus.wr_last[select_q] || beat_cnt == LAST_BEAT) begin
            state    <= IDLE;
            enable_q <= 1'b0;
            grant_q  <= '0;
            ptr      <= next_port(select_q, num_of_ports);
            if (!bus.wr_req[select_q]) begin
              abort_q <= 1'b1;
            end else begin
              done_q  <= 1'b1;
            end
          end else begin
            beat_cnt <= beat_cnt + 1'b1;
            enable_q <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          enable_q <= 1'b0;
          grant_q  <= '0;
        end
      endcase
    end
  end

  assign bus.enable    = enable_q;
  assign bus.select    = select_q;
  assign bus.grant     = grant_q;
  assign bus.pkt_done  = done_q;
  assign bus.pkt_abort = abort_q;

endmodule
